bus_activity_meter: RTL and testbench
=====================================

# bus_activity_meter

Switching-activity monitor that sits directly downstream of the low-power bus encoders (normal, bus-invert, Gray, transition-based, T0). It samples the encoded bus each enabled cycle and counts bit transitions: the per-cycle Hamming distance to the previous sample. It accumulates the count over a fixed window of samples and publishes per-window totals. In parallel, it checks that the decoder output matches the original input delayed by the encoder/decoder latency, so power comparisons and functional checks come from one in-design block.

## Interface

- Parameters:
- W, 9: monitored encoded-bus width (covers the 8-bit bus plus INV/INC line)
- DW, 8: data width of original and decoded words
- LAT, 1: encoder-to-decoder latency in enabled samples, 0..7
- WIN, 256: samples per window; power of two, at least 2
- CW, 16: window toggle-accumulator width
- Ports:
- ck  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  sample enable; bus_i/ref_i/dec_i are valid when high
- clr  in  1  synchronous clear of window state and baseline
- bus_i  in  W  encoded bus (encoder B output)
- ref_i  in  DW  original word presented to the encoder (A)
- dec_i  in  DW  decoder output (C)
- win_toggles  out  CW  total transitions in the last closed window, saturating
- win_peak  out  clog2(W+1)  maximum per-sample transitions in the last window
- win_err  out  8  decode mismatches in the last window, saturating at 255
- win_sat  out  1  win_toggles saturated in the last window
- win_valid  out  1  one-cycle pulse when the win_* outputs update

## Operation

- States:
  - BASE: no previous sample. This is the state after rst or clr.
  - RUN.
- Transitions:
  - BASE, en=1: capture bus_i as prev, hd=0, count the sample in the window, move to RUN.
  - RUN, en=1: hd = popcount(bus_i ^ prev); prev <= bus_i. acc <= min(acc+hd, 2^CW-1); sat set if the clamp engages. peak <= max(peak, hd).
- en=0: nothing changes. prev is held, and gaps produce no transitions.
- Window counter:
  - Counts enabled samples, 0..WIN-1.
  - The WIN-th sample's hd is included in the closing window.
  - On that edge, publish acc/peak/err/sat to the win_* outputs, pulse win_valid, and reset acc/peak/err/sat/counter to 0.
  - prev and RUN state are kept across the boundary.
- Decode check:
  - LAT-deep delay line of ref_i plus valid bits, shifted only on en.
  - When en=1 and the delayed entry is valid, compare it with dec_i; a mismatch increments err (saturating).
  - LAT=0 compares ref_i and dec_i in the same sample.
  - The delay line is flushed by rst/clr, so no compares occur until it refills.
- clr:
  - Returns to BASE and zeroes acc/peak/err/sat/counter/delay-valid.
  - The win_* outputs hold their last published values.
  - clr together with en: clr wins and the sample is discarded.

## Timing

- Reset values:
  - All outputs 0, win_valid 0, state BASE.
  - All internal counters and registers 0.
- All outputs are registered.
- win_* update on the rising edge that captures the WIN-th enabled sample.
- win_valid is high for exactly the following cycle. If the next window also closes on the next edge, which is impossible for WIN≥2, no special case applies.
- rst mid-window: immediate clear with no partial publish; win_valid is forced to 0 asynchronously.
- Latency from a sample to its contribution in acc is 1 edge. Compare latency follows LAT enabled samples, not cycles.

## Structure

- Shared package bam_pkg holds:
  - popcount function
  - default parameter constants (W, DW, WIN, CW)
  - state enum {BASE, RUN}
- One natural sub-module: bam_delay, a LAT-deep enabled shift register with per-stage valid bits, handling LAT=0 as a bypass.
- Everything else lives in bus_activity_meter.

## Test plan

- Reset, WIN=4, bus_i=0x000 for 4 enabled samples -> win_valid one cycle after the 4th edge; win_toggles=0, win_peak=0, win_err=0.
- WIN=4, bus_i alternating 0x000/0x1FF for 8 samples -> window 1 win_toggles=27 (baseline hd 0), peak 9; window 2 win_toggles=36, peak 9.
- CW=4, WIN=4, alternating 0x000/0x1FF -> win_toggles=15, win_sat=1.
- LAT=1, dec_i = ref_i delayed one sample with one corrupted word -> win_err=1. Same run with clean data -> 0, and no compare on the first sample after reset.
- WIN=4: 2 samples, then clr together with en=1 -> no win_valid. The next sample is the new baseline, and the window closes 4 samples later with counts excluding pre-clr data.
- en toggled 1,0,0,1 with bus_i changing only during en=0 cycles -> those changes are not counted. Toggles are computed against the last enabled sample, and the window counter advances only on en.

Source files
------------

// File: rtl/bam_pkg.sv
// Shared definitions for the bus activity meter: defaults, state encoding,
// and the popcount helper used for per-sample Hamming distance.
package bam_pkg;

  localparam int BAM_W   = 9;
  localparam int BAM_DW  = 8;
  localparam int BAM_WIN = 256;
  localparam int BAM_CW  = 16;

  // Widest bus the popcount helper accepts; narrower buses are zero-extended.
  localparam int POP_MAXW = 64;

  typedef enum logic {
    BASE = 1'b0,
    RUN  = 1'b1
  } bam_state_e;

  function automatic int unsigned popcount(input logic [POP_MAXW-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAXW; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/bam_delay.sv
// Enabled shift register that aligns the original word with the decoder
// output. Each stage carries a valid bit so compares start only once the
// line has refilled after rst/clr. LAT=0 is a pure bypass, always valid.
module bam_delay
  import bam_pkg::*;
#(
  parameter int DW  = BAM_DW,
  parameter int LAT = 1
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o,
  output logic          vld_o
);

  if (LAT == 0) begin : g_bypass
    // Nothing is stored, so the control inputs have no effect here.
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, ck, rst, en, clr};
    assign q_o   = d_i;
    assign vld_o = 1'b1;
  end else begin : g_line
    logic [DW-1:0] data_q [LAT];
    logic          vld_q  [LAT];

    for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
      // One stage: advances only on an accepted sample, flushed by clr.
      always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
          data_q[gi] <= '0;
          vld_q[gi]  <= 1'b0;
        end else if (clr) begin
          data_q[gi] <= '0;
          vld_q[gi]  <= 1'b0;
        end else if (en) begin
          if (gi == 0) begin
            data_q[gi] <= d_i;
            vld_q[gi]  <= 1'b1;
          end else begin
            data_q[gi] <= data_q[gi-1];
            vld_q[gi]  <= vld_q[gi-1];
          end
        end
      end
    end

    assign q_o   = data_q[LAT-1];
    assign vld_o = vld_q[LAT-1];
  end

endmodule

// File: rtl/bus_activity_meter.sv
// Switching-activity monitor for an encoded bus: counts bit transitions per
// enabled sample, accumulates them over fixed windows, and checks the decoder
// output against the original word delayed by the codec latency.
module bus_activity_meter
  import bam_pkg::*;
#(
  parameter int W   = BAM_W,
  parameter int DW  = BAM_DW,
  parameter int LAT = 1,
  parameter int WIN = BAM_WIN,
  parameter int CW  = BAM_CW
) (
  input  logic                   ck,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clr,
  input  logic [W-1:0]           bus_i,
  input  logic [DW-1:0]          ref_i,
  input  logic [DW-1:0]          dec_i,
  output logic [CW-1:0]          win_toggles,
  output logic [$clog2(W+1)-1:0] win_peak,
  output logic [7:0]             win_err,
  output logic                   win_sat,
  output logic                   win_valid
);

  localparam int PW   = $clog2(W + 1);
  localparam int CTRW = $clog2(WIN);

  bam_state_e state_q, state_d;
  logic       have_prev;

  logic [W-1:0]    prev_q, prev_d;
  logic [CW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   peak_q, peak_d;
  logic [7:0]      err_q, err_d;
  logic            sat_q, sat_d;
  logic [CTRW-1:0] cnt_q, cnt_d;

  logic [CW-1:0]   win_toggles_q, win_toggles_d;
  logic [PW-1:0]   win_peak_q, win_peak_d;
  logic [7:0]      win_err_q, win_err_d;
  logic            win_sat_q, win_sat_d;
  logic            win_valid_q, win_valid_d;

  logic [DW-1:0]   dly_ref;
  logic            dly_vld;

  logic [PW-1:0]   hd;
  logic [CW:0]     sum;
  logic            clamp;
  logic [CW-1:0]   acc_new;
  logic [PW-1:0]   peak_new;
  logic [7:0]      err_new;
  logic            last;

  // Original word aligned to the decoder output.
  bam_delay #(.DW(DW), .LAT(LAT)) u_delay (
    .ck    (ck),
    .rst   (rst),
    .en    (en),
    .clr   (clr),
    .d_i   (ref_i),
    .q_o   (dly_ref),
    .vld_o (dly_vld)
  );

  // State register.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) state_q <= BASE;
    else     state_q <= state_d;
  end

  // Next state: clr drops the baseline, any accepted sample establishes one.
  always_comb begin
    state_d = state_q;
    if (clr)     state_d = BASE;
    else if (en) state_d = RUN;
  end

  // FSM output: transitions are only meaningful once a baseline exists.
  always_comb begin
    have_prev = (state_q == RUN);
  end

  // Per-sample arithmetic: Hamming distance, clamped sum, peak, error count.
  always_comb begin
    hd       = have_prev ? PW'(popcount(POP_MAXW'(bus_i ^ prev_q))) : '0;
    sum      = {1'b0, acc_q} + (CW+1)'(hd);
    clamp    = sum[CW];
    acc_new  = clamp ? '1 : sum[CW-1:0];
    peak_new = (hd > peak_q) ? hd : peak_q;
    err_new  = (dly_vld && (dly_ref != dec_i) && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
    last     = (cnt_q == CTRW'(WIN - 1));
  end

  // Window bookkeeping: accumulate, or publish and restart on the last sample.
  always_comb begin
    prev_d        = prev_q;
    acc_d         = acc_q;
    peak_d        = peak_q;
    err_d         = err_q;
    sat_d         = sat_q;
    cnt_d         = cnt_q;
    win_toggles_d = win_toggles_q;
    win_peak_d    = win_peak_q;
    win_err_d     = win_err_q;
    win_sat_d     = win_sat_q;
    win_valid_d   = 1'b0;
    if (clr) begin
      // Published results survive clr; only the running window is dropped.
      prev_d = '0;
      acc_d  = '0;
      peak_d = '0;
      err_d  = '0;
      sat_d  = 1'b0;
      cnt_d  = '0;
    end else if (en) begin
      prev_d = bus_i;
      if (last) begin
        win_toggles_d = acc_new;
        win_peak_d    = peak_new;
        win_err_d     = err_new;
        win_sat_d     = sat_q | clamp;
        win_valid_d   = 1'b1;
        acc_d         = '0;
        peak_d        = '0;
        err_d         = '0;
        sat_d         = 1'b0;
        cnt_d         = '0;
      end else begin
        acc_d  = acc_new;
        peak_d = peak_new;
        err_d  = err_new;
        sat_d  = sat_q | clamp;
        cnt_d  = cnt_q + 1'b1;
      end
    end
  end

  // Datapath and output registers; rst clears everything with no publish.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      prev_q        <= '0;
      acc_q         <= '0;
      peak_q        <= '0;
      err_q         <= '0;
      sat_q         <= 1'b0;
      cnt_q         <= '0;
      win_toggles_q <= '0;
      win_peak_q    <= '0;
      win_err_q     <= '0;
      win_sat_q     <= 1'b0;
      win_valid_q   <= 1'b0;
    end else begin
      prev_q        <= prev_d;
      acc_q         <= acc_d;
      peak_q        <= peak_d;
      err_q         <= err_d;
      sat_q         <= sat_d;
      cnt_q         <= cnt_d;
      win_toggles_q <= win_toggles_d;
      win_peak_q    <= win_peak_d;
      win_err_q     <= win_err_d;
      win_sat_q     <= win_sat_d;
      win_valid_q   <= win_valid_d;
    end
  end

  assign win_toggles = win_toggles_q;
  assign win_peak    = win_peak_q;
  assign win_err     = win_err_q;
  assign win_sat     = win_sat_q;
  assign win_valid   = win_valid_q;

endmodule

// File: tb/tb_bus_activity_meter.sv
// Scoreboard bench: two meters (CW=16 and CW=4, both WIN=4, LAT=1) share
// stimulus; expected window results are queued before each run of samples
// and monitors pop and compare whenever win_valid is seen.
module tb_bus_activity_meter;

  typedef struct {
    logic [15:0] tog;
    logic [3:0]  peak;
    logic [7:0]  err;
    logic        sat;
  } exp_t;

  logic       ck;
  logic       rst;
  logic       en;
  logic       clr;
  logic [8:0] bus;
  logic [7:0] ref_w;
  logic [7:0] dec;

  logic [15:0] a_tog;
  logic [3:0]  a_peak;
  logic [7:0]  a_err;
  logic        a_sat;
  logic        a_valid;
  logic [3:0]  b_tog;
  logic [3:0]  b_peak;
  logic [7:0]  b_err;
  logic        b_sat;
  logic        b_valid;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0;
  int   errors = 0;

  bus_activity_meter #(.W(9), .DW(8), .LAT(1), .WIN(4), .CW(16)) dut_a (
    .ck(ck), .rst(rst), .en(en), .clr(clr), .bus_i(bus), .ref_i(ref_w), .dec_i(dec),
    .win_toggles(a_tog), .win_peak(a_peak), .win_err(a_err), .win_sat(a_sat), .win_valid(a_valid)
  );

  bus_activity_meter #(.W(9), .DW(8), .LAT(1), .WIN(4), .CW(4)) dut_b (
    .ck(ck), .rst(rst), .en(en), .clr(clr), .bus_i(bus), .ref_i(ref_w), .dec_i(dec),
    .win_toggles(b_tog), .win_peak(b_peak), .win_err(b_err), .win_sat(b_sat), .win_valid(b_valid)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic push(input logic [15:0] tog_a, input logic [3:0] peak, input logic [7:0] err,
                      input logic sat_a, input logic [15:0] tog_b, input logic sat_b);
    exp_t e;
    e.tog = tog_a; e.peak = peak; e.err = err; e.sat = sat_a;
    q_a.push_back(e);
    e.tog = tog_b; e.sat = sat_b;
    q_b.push_back(e);
  endtask

  // One clock of stimulus; inputs change 1 time unit after the active edge.
  task automatic smp(input logic e, input logic c, input logic [8:0] b,
                     input logic [7:0] r, input logic [7:0] d);
    en = e; clr = c; bus = b; ref_w = r; dec = d;
    @(posedge ck);
    #1;
    en = 1'b0; clr = 1'b0;
  endtask

  // Monitor for the wide-accumulator meter.
  always @(negedge ck) begin
    if (a_valid === 1'b1) begin
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_valid: got win_valid=1 expected no window");
      end else begin
        exp_t e;
        e = q_a.pop_front();
        chk("a_win_toggles", 32'(a_tog), 32'(e.tog));
        chk("a_win_peak", 32'(a_peak), 32'(e.peak));
        chk("a_win_err", 32'(a_err), 32'(e.err));
        chk("a_win_sat", 32'(a_sat), 32'(e.sat));
      end
    end
  end

  // Monitor for the narrow, saturating meter.
  always @(negedge ck) begin
    if (b_valid === 1'b1) begin
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_valid: got win_valid=1 expected no window");
      end else begin
        exp_t e;
        e = q_b.pop_front();
        chk("b_win_toggles", 32'(b_tog), 32'(e.tog));
        chk("b_win_peak", 32'(b_peak), 32'(e.peak));
        chk("b_win_err", 32'(b_err), 32'(e.err));
        chk("b_win_sat", 32'(b_sat), 32'(e.sat));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] refs [4];
    logic [7:0] decs [4];
    rst = 1'b1; en = 1'b0; clr = 1'b0; bus = '0; ref_w = '0; dec = '0;
    repeat (2) @(posedge ck);
    #1;
    chk("reset_toggles", 32'(a_tog), 32'd0);
    chk("reset_peak", 32'(a_peak), 32'd0);
    chk("reset_err", 32'(a_err), 32'd0);
    chk("reset_sat", 32'(a_sat), 32'd0);
    chk("reset_valid", 32'(a_valid), 32'd0);
    rst = 1'b0;

    // Quiet bus: empty window.
    push(16'd0, 4'd0, 8'd0, 1'b0, 16'd0, 1'b0);
    for (int i = 0; i < 4; i++) smp(1'b1, 1'b0, 9'h000, 8'h00, 8'h00);

    // Full-width alternation: baseline window 0+9+9+9, then 4x9.
    smp(1'b0, 1'b1, 9'h000, 8'h00, 8'h00);
    push(16'd27, 4'd9, 8'd0, 1'b0, 16'd15, 1'b1);
    push(16'd36, 4'd9, 8'd0, 1'b0, 16'd15, 1'b1);
    for (int i = 0; i < 8; i++) smp(1'b1, 1'b0, (i % 2 == 1) ? 9'h1FF : 9'h000, 8'h00, 8'h00);

    // rst right after a window closes: pulse is killed, nothing published.
    smp(1'b0, 1'b1, 9'h000, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) smp(1'b1, 1'b0, (i % 2 == 1) ? 9'h1FF : 9'h000, 8'h00, 8'h00);
    rst = 1'b1;
    #2;
    chk("rst_kills_valid", 32'(a_valid), 32'd0);
    chk("rst_clears_toggles", 32'(a_tog), 32'd0);
    chk("rst_clears_peak", 32'(b_peak), 32'd0);
    repeat (2) @(posedge ck);
    #1;
    rst = 1'b0;

    // Clean LAT=1 stream after reset; first sample's garbage dec is not compared.
    refs = '{8'h55, 8'h66, 8'h77, 8'h88};
    decs = '{8'hEE, 8'h55, 8'h66, 8'h77};
    push(16'd0, 4'd0, 8'd0, 1'b0, 16'd0, 1'b0);
    for (int i = 0; i < 4; i++) smp(1'b1, 1'b0, 9'h000, refs[i], decs[i]);

    // One corrupted decoded word after clr.
    smp(1'b0, 1'b1, 9'h000, 8'h00, 8'h00);
    refs = '{8'h11, 8'h22, 8'h33, 8'h44};
    decs = '{8'hEE, 8'h11, 8'h5A, 8'h33};
    push(16'd0, 4'd0, 8'd1, 1'b0, 16'd0, 1'b0);
    for (int i = 0; i < 4; i++) smp(1'b1, 1'b0, 9'h000, refs[i], decs[i]);

    // clr with en discards the sample and the partial window.
    smp(1'b0, 1'b1, 9'h000, 8'h00, 8'h00);
    push(16'd3, 4'd1, 8'd0, 1'b0, 16'd3, 1'b0);
    smp(1'b1, 1'b0, 9'h0FF, 8'h00, 8'h00);
    smp(1'b1, 1'b0, 9'h000, 8'h00, 8'h00);
    smp(1'b1, 1'b1, 9'h1FF, 8'h00, 8'h00);
    smp(1'b1, 1'b0, 9'h001, 8'h00, 8'h00);
    smp(1'b1, 1'b0, 9'h003, 8'h00, 8'h00);
    smp(1'b1, 1'b0, 9'h007, 8'h00, 8'h00);
    smp(1'b1, 1'b0, 9'h00F, 8'h00, 8'h00);

    // Bus changes while en=0 are invisible.
    smp(1'b0, 1'b1, 9'h000, 8'h00, 8'h00);
    push(16'd2, 4'd1, 8'd0, 1'b0, 16'd2, 1'b0);
    smp(1'b1, 1'b0, 9'h000, 8'h00, 8'h00);
    smp(1'b0, 1'b0, 9'h1FF, 8'h00, 8'h00);
    smp(1'b0, 1'b0, 9'h0F0, 8'h00, 8'h00);
    smp(1'b1, 1'b0, 9'h001, 8'h00, 8'h00);
    smp(1'b1, 1'b0, 9'h003, 8'h00, 8'h00);
    smp(1'b1, 1'b0, 9'h003, 8'h00, 8'h00);

    repeat (4) @(posedge ck);
    #1;
    chk("a_windows_left", 32'(q_a.size()), 32'd0);
    chk("b_windows_left", 32'(q_b.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
